// File: rtl/adam_pause_sequencer.sv
// Fans one upstream pause handshake out to NO_MSTS downstream handshakes,
// issuing them group by group with an optional reversed resume order and a per-group watchdog.
module adam_pause_sequencer #(
  parameter int          NO_MSTS        = 8,
  parameter int          GROUP_SIZE     = NO_MSTS,
  parameter bit          REVERSE_RESUME = 1'b1,
  parameter int unsigned TIMEOUT        = 0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        slv_req,
  output logic                                        slv_ack,
  output logic [NO_MSTS-1:0]                          mst_req,
  input  logic [NO_MSTS-1:0]                          mst_ack,
  input  logic [NO_MSTS-1:0]                          en,
  output logic                                        busy,
  output logic                                        timeout,
  output logic [(NO_MSTS > 1 ? $clog2(NO_MSTS) : 1)-1:0] timeout_idx
);

  localparam int NO_GROUPS = (NO_MSTS + GROUP_SIZE - 1) / GROUP_SIZE;
  localparam int GW        = (NO_GROUPS > 1) ? $clog2(NO_GROUPS) : 1;
  localparam int IW        = (NO_MSTS > 1) ? $clog2(NO_MSTS) : 1;
  localparam int CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [GW-1:0] LAST_GRP = GW'(NO_GROUPS - 1);
  localparam logic [CW-1:0] TO_VAL   = CW'(TIMEOUT);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_dir, w_dir_nxt;
  logic [NO_MSTS-1:0] r_emask, w_emask_nxt;
  logic [NO_MSTS-1:0] r_mst_req, w_mst_req_nxt;
  logic [GW-1:0]      r_grp, w_grp_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic               r_slv_ack, w_slv_ack_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic [IW-1:0]      r_timeout_idx, w_timeout_idx_nxt;

  logic               w_fwd;
  logic [GW-1:0]      w_first_grp;
  logic [GW-1:0]      w_last_grp;
  logic [GW-1:0]      w_grp_step;
  logic [NO_MSTS-1:0] w_pend;
  logic               w_grp_done;
  logic [IW-1:0]      w_pend_idx;
  logic               w_pend_found;
  logic [CW-1:0]      w_cnt_inc;

  function automatic logic [NO_MSTS-1:0] grp_mask(input logic [GW-1:0] g);
    logic [NO_MSTS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NO_MSTS; i++) begin
      m[i] = (GW'(i / GROUP_SIZE) == g);
    end
    return m;
  endfunction

  // Only the masked channels take the new direction; all others hold their request.
  function automatic logic [NO_MSTS-1:0] issue(input logic [NO_MSTS-1:0] cur,
                                               input logic [NO_MSTS-1:0] mask,
                                               input logic               dir);
    return (cur & ~mask) | ({NO_MSTS{dir}} & mask);
  endfunction

  assign w_fwd       = r_dir || !REVERSE_RESUME;
  assign w_first_grp = (!slv_req && REVERSE_RESUME) ? LAST_GRP : '0;
  assign w_last_grp  = w_fwd ? LAST_GRP : '0;
  assign w_grp_step  = w_fwd ? (r_grp + 1'b1) : (r_grp - 1'b1);
  assign w_pend      = r_emask & grp_mask(r_grp) & (mst_ack ^ {NO_MSTS{r_dir}});
  assign w_grp_done  = ~|w_pend;
  assign w_cnt_inc   = r_cnt + 1'b1;

  always_comb begin
    w_pend_idx   = '0;
    w_pend_found = 1'b0;
    for (int unsigned i = 0; i < NO_MSTS; i++) begin
      if (w_pend[i] && !w_pend_found) begin
        w_pend_idx   = IW'(i);
        w_pend_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_dir         <= 1'b1;
      r_emask       <= '1;
      r_mst_req     <= '1;
      r_grp         <= '0;
      r_cnt         <= '0;
      r_slv_ack     <= 1'b1;
      r_busy        <= 1'b0;
      r_timeout     <= 1'b0;
      r_timeout_idx <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_dir         <= w_dir_nxt;
      r_emask       <= w_emask_nxt;
      r_mst_req     <= w_mst_req_nxt;
      r_grp         <= w_grp_nxt;
      r_cnt         <= w_cnt_nxt;
      r_slv_ack     <= w_slv_ack_nxt;
      r_busy        <= w_busy_nxt;
      r_timeout     <= w_timeout_nxt;
      r_timeout_idx <= w_timeout_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_dir_nxt         = r_dir;
    w_emask_nxt       = r_emask;
    w_mst_req_nxt     = r_mst_req;
    w_grp_nxt         = r_grp;
    w_cnt_nxt         = r_cnt;
    w_slv_ack_nxt     = r_slv_ack;
    w_busy_nxt        = r_busy;
    w_timeout_nxt     = r_timeout;
    w_timeout_idx_nxt = r_timeout_idx;

    case (r_state)
      S_IDLE: begin
        if (slv_req != r_slv_ack) begin
          w_state_nxt   = S_WAIT;
          w_dir_nxt     = slv_req;
          w_emask_nxt   = en;
          w_grp_nxt     = w_first_grp;
          w_mst_req_nxt = issue(r_mst_req, en & grp_mask(w_first_grp), slv_req);
          w_busy_nxt    = 1'b1;
          w_timeout_nxt = 1'b0;
          w_cnt_nxt     = '0;
        end
      end

      S_WAIT: begin
        if (!w_grp_done) begin
          // Saturating watchdog; the flag is raised on the edge the count reaches TIMEOUT.
          if (TIMEOUT != 0 && r_cnt != TO_VAL) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == TO_VAL) begin
              w_timeout_nxt     = 1'b1;
              w_timeout_idx_nxt = w_pend_idx;
            end
          end
        end else if (r_grp != w_last_grp) begin
          w_grp_nxt     = w_grp_step;
          w_mst_req_nxt = issue(r_mst_req, r_emask & grp_mask(w_grp_step), r_dir);
          w_cnt_nxt     = '0;
        end else begin
          w_slv_ack_nxt = r_dir;
          w_busy_nxt    = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign slv_ack     = r_slv_ack;
  assign mst_req     = r_mst_req;
  assign busy        = r_busy;
  assign timeout     = r_timeout;
  assign timeout_idx = r_timeout_idx;

endmodule

// File: tb/tb_adam_pause_sequencer.sv
// Directed bench for adam_pause_sequencer: three instances cover parallel, sequential
// (random ack delays, reversed resume) and grouped-by-3 configurations.
module tb_adam_pause_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // u0: 8 channels, one group, watchdog of 10 cycles
  logic       slv_req0, slv_ack0, busy0, timeout0;
  logic [7:0] mst_req0, mst_ack0, en0, hold0, frozen0;
  logic [2:0] tidx0;
  assign mst_ack0 = (mst_req0 & ~hold0) | (frozen0 & hold0);

  // u1: one channel per group, reversed resume, random ack delays
  logic       slv_req1, slv_ack1, busy1, timeout1;
  logic [7:0] mst_req1;
  logic [7:0] mst_ack1 = '1;
  logic [7:0] en1 = '1;
  logic [2:0] tidx1;
  int         dly1[8];

  // u2: groups {0,1,2},{3,4,5},{6,7}, same order both ways, immediate acks
  logic       slv_req2, slv_ack2, busy2, timeout2;
  logic [7:0] mst_req2, mst_ack2;
  logic [7:0] en2 = '1;
  logic [2:0] tidx2;
  assign mst_ack2 = mst_req2;

  adam_pause_sequencer #(.NO_MSTS(8), .GROUP_SIZE(8), .REVERSE_RESUME(1'b1), .TIMEOUT(10)) u0 (
    .clk(clk), .rst(rst), .slv_req(slv_req0), .slv_ack(slv_ack0), .mst_req(mst_req0),
    .mst_ack(mst_ack0), .en(en0), .busy(busy0), .timeout(timeout0), .timeout_idx(tidx0));

  adam_pause_sequencer #(.NO_MSTS(8), .GROUP_SIZE(1), .REVERSE_RESUME(1'b1), .TIMEOUT(0)) u1 (
    .clk(clk), .rst(rst), .slv_req(slv_req1), .slv_ack(slv_ack1), .mst_req(mst_req1),
    .mst_ack(mst_ack1), .en(en1), .busy(busy1), .timeout(timeout1), .timeout_idx(tidx1));

  adam_pause_sequencer #(.NO_MSTS(8), .GROUP_SIZE(3), .REVERSE_RESUME(1'b0), .TIMEOUT(0)) u2 (
    .clk(clk), .rst(rst), .slv_req(slv_req2), .slv_ack(slv_ack2), .mst_req(mst_req2),
    .mst_ack(mst_ack2), .en(en2), .busy(busy2), .timeout(timeout2), .timeout_idx(tidx2));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // u1 downstream responders: each channel follows its request after 0..100 cycles
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        if (mst_req1[i] !== mst_ack1[i]) begin
          if (dly1[i] == 0) begin
            mst_ack1[i] = mst_req1[i];
            dly1[i]     = $urandom_range(0, 100);
          end else begin
            dly1[i] = dly1[i] - 1;
          end
        end
      end
    end
  end

  // u1 monitor: order of request changes, overlap of outstanding channels, early slv_ack
  int unsigned order1[$];
  int          ovl1  = 0;
  int          early1 = 0;
  logic [7:0]  prev_req1 = '1;
  logic        prev_ack1 = 1'b1;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      if ($countones(mst_req1 ^ prev_req1) > 1) ovl1++;
      if ($countones(mst_req1 ^ mst_ack1) > 1) ovl1++;
      for (int i = 0; i < 8; i++)
        if (mst_req1[i] !== prev_req1[i]) order1.push_back(i);
      if (slv_ack1 !== prev_ack1 && mst_ack1 !== {8{slv_ack1}}) early1++;
      prev_req1 = mst_req1;
      prev_ack1 = slv_ack1;
    end
  end

  task automatic run_u1(input logic dir);
    int c;
    order1.delete();
    slv_req1 = dir;
    c = 0;
    while (slv_ack1 !== dir && c < 3000) begin
      step(1);
      c++;
    end
    step(1);
    chk("u1_done", slv_ack1, dir);
    chk("u1_order_len", order1.size(), 8);
    for (int i = 0; i < 8 && i < order1.size(); i++)
      chk("u1_order", order1[i], dir ? i : 7 - i);
    chk("u1_overlap", ovl1, 0);
    chk("u1_early_ack", early1, 0);
    chk("u1_req_final", mst_req1, dir ? 8'hFF : 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    slv_req0 = 1'b1; slv_req1 = 1'b1; slv_req2 = 1'b1;
    en0 = '1; hold0 = '0; frozen0 = '0;
    step(3);
    chk("rst_req0", mst_req0, 8'hFF);
    chk("rst_ack0", slv_ack0, 1);
    chk("rst_busy0", busy0, 0);
    chk("rst_to0", timeout0, 0);
    chk("rst_idx0", tidx0, 0);
    chk("rst_req1", mst_req1, 8'hFF);
    chk("rst_req2", mst_req2, 8'hFF);
    rst = 1'b1;
    step(2);
    chk("idle_req0", mst_req0, 8'hFF);
    chk("idle_busy0", busy0, 0);

    // parallel resume with immediate acks
    slv_req0 = 1'b0;
    step(1);
    chk("lat_busy", busy0, 1);
    chk("lat_req", mst_req0, 8'h00);
    chk("lat_ack_k", slv_ack0, 1);
    step(1);
    chk("lat_ack_k1", slv_ack0, 0);
    chk("lat_idle", busy0, 0);

    // groups of 3, forward in both directions
    slv_req2 = 1'b0;
    step(1); chk("g3_res0", mst_req2, 8'hF8);
    step(1); chk("g3_res1", mst_req2, 8'hC0); chk("g3_res1_ack", slv_ack2, 1);
    step(1); chk("g3_res2", mst_req2, 8'h00); chk("g3_res2_ack", slv_ack2, 1);
    step(1); chk("g3_res_ack", slv_ack2, 0);
    slv_req2 = 1'b1;
    step(1); chk("g3_pau0", mst_req2, 8'h07);
    step(1); chk("g3_pau1", mst_req2, 8'h3F);
    step(1); chk("g3_pau2", mst_req2, 8'hFF); chk("g3_pau2_ack", slv_ack2, 0);
    step(1); chk("g3_pau_ack", slv_ack2, 1);

    // sequential with random delays: resume 7..0, pause 0..7
    run_u1(1'b0);
    run_u1(1'b1);

    // enable mask: only odd channels resume
    slv_req0 = 1'b1;
    step(2);
    chk("en_pre_req", mst_req0, 8'hFF);
    chk("en_pre_ack", slv_ack0, 1);
    en0 = 8'hAA; slv_req0 = 1'b0;
    step(1); chk("en_mid", mst_req0, 8'h55);
    step(1); chk("en_done", mst_req0, 8'h55); chk("en_ack", slv_ack0, 0);
    en0 = '1; slv_req0 = 1'b1;
    step(2); chk("en_restore", mst_req0, 8'hFF);
    slv_req0 = 1'b0;
    step(2); chk("resume_all", mst_req0, 8'h00); chk("resume_ack", slv_ack0, 0);

    // watchdog: channel 3 withholds its pause ack
    frozen0 = mst_req0; hold0 = 8'h08; slv_req0 = 1'b1;
    step(1); chk("to_issue", mst_req0, 8'hFF);
    step(9); chk("to_pre", timeout0, 0);
    step(1); chk("to_set", timeout0, 1); chk("to_idx", tidx0, 3);
    step(5); chk("to_hold_ack", slv_ack0, 0); chk("to_hold_busy", busy0, 1);
    hold0 = '0;
    step(1); chk("to_done_ack", slv_ack0, 1); chk("to_sticky", timeout0, 1);
    slv_req0 = 1'b0;
    step(1); chk("to_clear", timeout0, 0);
    step(1); chk("to_next_ack", slv_ack0, 0);

    // slv_req toggled back mid-transaction
    frozen0 = mst_req0; hold0 = 8'h08; slv_req0 = 1'b1;
    step(3);
    slv_req0 = 1'b0;
    step(2); chk("tog_busy", busy0, 1); chk("tog_ack_hold", slv_ack0, 0);
    hold0 = '0;
    step(1); chk("tog_ack_orig", slv_ack0, 1); chk("tog_req_orig", mst_req0, 8'hFF);
    chk("tog_idle", busy0, 0);
    step(1); chk("tog_restart_busy", busy0, 1); chk("tog_restart_req", mst_req0, 8'h00);
    step(1); chk("tog_second_ack", slv_ack0, 0);

    // reset in the middle of a transaction
    frozen0 = mst_req0; hold0 = 8'h08; slv_req0 = 1'b1;
    step(3); chk("mrst_busy_pre", busy0, 1);
    rst = 1'b0;
    step(1);
    chk("mrst_req", mst_req0, 8'hFF);
    chk("mrst_ack", slv_ack0, 1);
    chk("mrst_busy", busy0, 0);
    chk("mrst_to", timeout0, 0);
    rst = 1'b1; hold0 = '0;
    step(2);
    chk("mrst_after_busy", busy0, 0);
    chk("mrst_u1", mst_req1, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adam_pause_sequencer.md
# adam_pause_sequencer

Fans one pause request/acknowledge handshake out to NO_MSTS downstream pause handshakes and sequences them in groups: all at once, one at a time, or GROUP_SIZE at a time. Resume optionally runs in reverse group order. It is the next generation of the pause demultiplexer. It adds a per-channel enable mask, an ordered group sequence, a per-group watchdog, and status outputs. It sits between a power/clock controller's pause master and the peripheral pause slaves of a subsystem.

## Interface
- NO_MSTS, 8, number of downstream pause channels (1..32)
- GROUP_SIZE, NO_MSTS, channels per group; 1 = strictly sequential, NO_MSTS = fully parallel; NO_GROUPS = ceil(NO_MSTS/GROUP_SIZE), last group may be partial
- REVERSE_RESUME, 1, 1 = resume processes groups last-to-first; 0 = same order as pause
- TIMEOUT, 0, cycles a group may wait before flagging; 0 disables the watchdog
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  reset, synchronous, active-low
- slv_req  input  1  upstream pause request (1 = pause, 0 = resume)
- slv_ack  output  1  upstream acknowledge; follows slv_req when the whole sequence completes
- mst_req  output  NO_MSTS  downstream requests, registered
- mst_ack  input  NO_MSTS  downstream acknowledges
- en  input  NO_MSTS  channel enable mask, sampled at transaction start
- busy  output  1  high while a transaction is in progress
- timeout  output  1  sticky watchdog flag, cleared at next transaction start
- timeout_idx  output  $clog2(NO_MSTS) (min 1)  lowest non-acked enabled channel when timeout set

## Operation
- Protocol is level-based: a side is paused when req = ack = 1 and running when req = ack = 0. A transaction is pending when slv_req != slv_ack.
- Reset (rst = 0 at an edge): all mst_req = 1, slv_ack = 1, busy = 0, timeout = 0, timeout_idx = 0, state IDLE. The system comes out of reset paused.
- States are IDLE and WAIT.
- IDLE to WAIT: taken when slv_req != slv_ack. At that edge:
  - latch dir = slv_req and emask = en.
  - set grp to the first group: 0, or NO_GROUPS-1 if dir = 0 and REVERSE_RESUME = 1.
  - drive mst_req[i] = dir for enabled channels of grp.
  - busy = 1, clear timeout, clear the watchdog counter.
- WAIT: the group is complete when every enabled channel i in grp has mst_ack[i] == dir.
  - If the group is not complete, the watchdog counter increments.
  - If the group is complete and is not the last group, step grp (+1 or -1 per direction), drive the new group's enabled mst_req = dir, and clear the counter.
  - If the group is complete and is the last group, set slv_ack = dir, busy = 0, and go to IDLE.
- Disabled channels keep their mst_req value unchanged throughout the transaction. A group with no enabled channels completes on its first WAIT cycle.
- Watchdog: when TIMEOUT != 0 and the counter reaches TIMEOUT, set timeout = 1 and capture timeout_idx. The block keeps waiting and never forces completion. The counter saturates.
- If slv_req toggles during WAIT, the change is ignored; dir stays latched. After completion slv_ack != slv_req, so a new transaction starts from IDLE on the next edge.
- If en changes mid-transaction, it has no effect until the next transaction.
- If rst is asserted mid-transaction, the block returns to the reset values at that edge regardless of state.

## Timing
- A slv_req change sampled at edge k makes the first group's mst_req visible after edge k.
- If each group's acks respond combinationally, one group completes per cycle. slv_ack then changes after edge k+NO_GROUPS, so latency = NO_GROUPS+1 edges from the slv_req edge.
- Each additional cycle of mst_ack delay adds one cycle per affected group.
- Groups never overlap: mst_req for group g+1 (or g-1) changes only after group g is complete.
- slv_ack changes exactly once per transaction; mst_req of an enabled channel changes at most once per transaction.
- timeout is asserted at the edge where the counter equals TIMEOUT, that is TIMEOUT cycles after the group was issued.

## Test plan
- Reset then release, slv_req = 1, all en = 1 -> mst_req = 8'hFF, slv_ack = 1, busy = 0. Drop slv_req with immediate acks (NO_MSTS=8, GROUP_SIZE=8) -> slv_ack = 0 exactly 2 edges later.
- GROUP_SIZE = 1, REVERSE_RESUME = 1, random 0-100 cycle ack delays per channel:
  - resume -> mst_req bits fall in order 7,6,...,0, one at a time;
  - pause -> bits rise in order 0..7;
  - slv_ack only after the last ack.
- GROUP_SIZE = 3, NO_MSTS = 8 -> groups {0,1,2}, {3,4,5}, {6,7}; with immediate acks, slv_ack latency = 4 edges.
- en = 8'b1010_1010 during resume -> mst_req = 8'b0101_0101 after completion; channels 0,2,4,6 never toggle.
- TIMEOUT = 10, channel 3 withholds ack -> timeout = 1 and timeout_idx = 3 exactly 10 cycles after the group issue. slv_ack does not change until channel 3 acks; timeout clears at the next transaction start.
- Toggle slv_req back mid-WAIT -> the current transaction completes in the original direction, then a second transaction runs; assert rst mid-WAIT -> all mst_req = 1 and slv_ack = 1 after that edge.
